// File: rtl/accumulator.sv
// Partial-sum accumulator for a PE column: adds the PE output to a bias/psum or to its own result.
// Overflow behaviour is selected at build time by ACC_SAT_EN (defined: saturate, undefined: wrap).
module accumulator #(
   parameter int PSUM_WID = 24
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic                       use_acc,
   input  logic signed [PSUM_WID-1:0] pe_out,
   input  logic signed [PSUM_WID-1:0] psum_or_bias,
   output logic signed [PSUM_WID-1:0] result,
   output logic                       out_valid,
   output logic                       ovf
);

   localparam logic signed [PSUM_WID-1:0] SUM_MAX = {1'b0, {(PSUM_WID-1){1'b1}}};
   localparam logic signed [PSUM_WID-1:0] SUM_MIN = {1'b1, {(PSUM_WID-1){1'b0}}};

   logic signed [PSUM_WID-1:0] addend;
   logic signed [PSUM_WID:0]   sum_full;
   logic                       overflow;
   logic signed [PSUM_WID-1:0] sum_next;

   always_comb begin
      addend   = use_acc ? result : psum_or_bias;
      sum_full = {pe_out[PSUM_WID-1], pe_out} + {addend[PSUM_WID-1], addend};
      // The extra bit keeps the true sign; disagreement with the next bit means out of range.
      overflow = sum_full[PSUM_WID] ^ sum_full[PSUM_WID-1];
`ifdef ACC_SAT_EN
      if (overflow)
         sum_next = sum_full[PSUM_WID] ? SUM_MIN : SUM_MAX;
      else
         sum_next = sum_full[PSUM_WID-1:0];
`else
      sum_next = sum_full[PSUM_WID-1:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result    <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else if (in_valid) begin
         result    <= sum_next;
         out_valid <= 1'b1;
         ovf       <= overflow;
      end else begin
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_accumulator.sv
// Directed bench for accumulator: a 24-bit instance for the datapath cases and a 16-bit
// instance for the overflow corners; expected overflow results follow ACC_SAT_EN.
module tb_accumulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic               in_valid_a, use_acc_a;
   logic signed [23:0] pe_out_a, psum_or_bias_a, result_a;
   logic               out_valid_a, ovf_a;

   logic               in_valid_b, use_acc_b;
   logic signed [15:0] pe_out_b, psum_or_bias_b, result_b;
   logic               out_valid_b, ovf_b;

   int checks = 0;
   int errors = 0;

   accumulator #(.PSUM_WID(24)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid_a), .use_acc(use_acc_a),
      .pe_out(pe_out_a), .psum_or_bias(psum_or_bias_a),
      .result(result_a), .out_valid(out_valid_a), .ovf(ovf_a)
   );

   accumulator #(.PSUM_WID(16)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .use_acc(use_acc_b),
      .pe_out(pe_out_b), .psum_or_bias(psum_or_bias_b),
      .result(result_b), .out_valid(out_valid_b), .ovf(ovf_b)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic u, input int pe, input int pb);
      in_valid_a     = v;
      use_acc_a      = u;
      pe_out_a       = 24'(pe);
      psum_or_bias_a = 24'(pb);
   endtask

   task automatic drive_b(input logic v, input logic u, input int pe, input int pb);
      in_valid_b     = v;
      use_acc_b      = u;
      pe_out_b       = 16'(pe);
      psum_or_bias_b = 16'(pb);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_a(1'b1, 1'b0, 5, 0);
      drive_b(1'b1, 1'b0, 5, 0);
      cyc();
      cyc();
      checks++;
      if (result_a !== 24'sd0 || out_valid_a !== 1'b0 || ovf_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_a: result=%0d out_valid=%b ovf=%b, required 0 0 0", result_a, out_valid_a, ovf_a);
      end
      checks++;
      if (result_b !== 16'sd0 || out_valid_b !== 1'b0 || ovf_b !== 1'b0) begin
         errors++;
         $display("FAIL reset_b: result=%0d out_valid=%b ovf=%b, required 0 0 0", result_b, out_valid_b, ovf_b);
      end
      rst = 1'b0;
      drive_a(1'b0, 1'b0, 0, 0);
      drive_b(1'b0, 1'b0, 0, 0);
      cyc();
      checks++;
      if (result_a !== 24'sd0 || out_valid_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: result=%0d out_valid=%b, required 0 0", result_a, out_valid_a);
      end
   endtask

   task automatic test_basic_signs();
      int pe  [4] = '{8, -8, 8, -8};
      int pb  [4] = '{9, 9, -9, -9};
      int exp [4] = '{17, 1, -1, -17};
      for (int i = 0; i < 4; i++) begin
         drive_a(1'b1, 1'b0, pe[i], pb[i]);
         cyc();
         checks++;
         if (result_a !== 24'(exp[i]) || out_valid_a !== 1'b1 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_%0d: result=%0d out_valid=%b ovf=%b, required %0d 1 0",
                     i, result_a, out_valid_a, ovf_a, exp[i]);
         end
      end
   endtask

   task automatic test_chain();
      int exp [4] = '{13, 16, 19, 22};
      for (int i = 0; i < 4; i++) begin
         // psum_or_bias is garbage on the feedback cycles to prove it is ignored
         if (i == 0) drive_a(1'b1, 1'b0, 3, 10);
         else        drive_a(1'b1, 1'b1, 3, 1000);
         cyc();
         checks++;
         if (result_a !== 24'(exp[i]) || out_valid_a !== 1'b1 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL chain_%0d: result=%0d out_valid=%b ovf=%b, required %0d 1 0",
                     i, result_a, out_valid_a, ovf_a, exp[i]);
         end
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 3; i++) begin
         drive_a(1'b0, 1'b1, 77, 55);
         cyc();
         checks++;
         if (result_a !== 24'sd22 || out_valid_a !== 1'b0 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d: result=%0d out_valid=%b ovf=%b, required 22 0 0",
                     i, result_a, out_valid_a, ovf_a);
         end
      end
   endtask

   task automatic test_reset_mid_chain();
      rst = 1'b1;
      drive_a(1'b1, 1'b1, 9, 9);
      cyc();
      rst = 1'b0;
      checks++;
      if (result_a !== 24'sd0 || out_valid_a !== 1'b0) begin
         errors++;
         $display("FAIL midreset_clear: result=%0d out_valid=%b, required 0 0", result_a, out_valid_a);
      end
      drive_a(1'b1, 1'b1, 4, 100);
      cyc();
      checks++;
      if (result_a !== 24'sd4 || out_valid_a !== 1'b1 || ovf_a !== 1'b0) begin
         errors++;
         $display("FAIL midreset_acc: result=%0d out_valid=%b ovf=%b, required 4 1 0", result_a, out_valid_a, ovf_a);
      end
      drive_a(1'b1, 1'b1, -10, 0);
      cyc();
      checks++;
      if (result_a !== -24'sd6) begin
         errors++;
         $display("FAIL midreset_acc2: result=%0d, required -6", result_a);
      end
      drive_a(1'b0, 1'b0, 0, 0);
   endtask

   task automatic test_overflow();
      int exp_pos;
      int exp_neg;
`ifdef ACC_SAT_EN
      exp_pos = 32767;
      exp_neg = -32768;
`else
      exp_pos = -32768;
      exp_neg = 32767;
`endif
      // largest in-range sum: no overflow
      drive_b(1'b1, 1'b0, 32766, 1);
      cyc();
      checks++;
      if (result_b !== 16'sd32767 || out_valid_b !== 1'b1 || ovf_b !== 1'b0) begin
         errors++;
         $display("FAIL ovf_edge_pos: result=%0d ovf=%b, required 32767 0", result_b, ovf_b);
      end
      drive_b(1'b1, 1'b0, 32767, 1);
      cyc();
      checks++;
      if (result_b !== 16'(exp_pos) || out_valid_b !== 1'b1 || ovf_b !== 1'b1) begin
         errors++;
         $display("FAIL ovf_pos: result=%0d out_valid=%b ovf=%b, required %0d 1 1",
                  result_b, out_valid_b, ovf_b, exp_pos);
      end
      drive_b(1'b1, 1'b0, -32768, -1);
      cyc();
      checks++;
      if (result_b !== 16'(exp_neg) || out_valid_b !== 1'b1 || ovf_b !== 1'b1) begin
         errors++;
         $display("FAIL ovf_neg: result=%0d out_valid=%b ovf=%b, required %0d 1 1",
                  result_b, out_valid_b, ovf_b, exp_neg);
      end
      drive_b(1'b1, 1'b0, -32767, -1);
      cyc();
      checks++;
      if (result_b !== -16'sd32768 || ovf_b !== 1'b0) begin
         errors++;
         $display("FAIL ovf_edge_neg: result=%0d ovf=%b, required -32768 0", result_b, ovf_b);
      end
      drive_b(1'b0, 1'b0, 32767, 32767);
      cyc();
      checks++;
      if (result_b !== -16'sd32768 || out_valid_b !== 1'b0 || ovf_b !== 1'b0) begin
         errors++;
         $display("FAIL ovf_idle: result=%0d out_valid=%b ovf=%b, required -32768 0 0",
                  result_b, out_valid_b, ovf_b);
      end
   endtask

   initial begin
      rst = 1'b1;
      drive_a(1'b0, 1'b0, 0, 0);
      drive_b(1'b0, 1'b0, 0, 0);
      test_reset();
      test_basic_signs();
      test_chain();
      test_hold();
      test_reset_mid_chain();
      test_overflow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
